// File: rtl/frame_pkg.sv
// Types and helpers shared by the frame serializer and the sample window register.
package frame_pkg;

   localparam int SAMPLE_W = 8;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic {IDLE, STREAM} ser_state_t;

   function automatic int idx_w(input int length);
      return (length > 1) ? $clog2(length) : 1;
   endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Valid/ready stream carrying one signed word per transfer, with an end-of-frame flag.
interface frame_serializer_if #(
   parameter int WORDWIDTH = frame_pkg::SAMPLE_W
) ();

   logic signed [WORDWIDTH-1:0] out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/frame_index_counter.sv
// Walks the snapshot index up or down from a start point and flags the Nth word.
module frame_index_counter
   import frame_pkg::*;
#(
   parameter int LENGTH = 1024,
   parameter int IDX_W  = idx_w(LENGTH),
   parameter int CNT_W  = $clog2(LENGTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             reverse_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             advance_i,
   output logic [IDX_W-1:0] next_idx_o,
   output logic             is_last_o,
   output logic             next_last_o
);

   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] remaining_q;
   logic             down_q;

   // remaining_q counts words still to follow the one currently presented.
   assign next_idx_o  = down_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
   assign is_last_o   = (remaining_q == '0);
   assign next_last_o = (remaining_q == CNT_W'(1));

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         remaining_q <= '0;
         down_q      <= 1'b0;
      end else if (load_i) begin
         idx_q       <= reverse_i ? IDX_W'(LENGTH - 1) : '0;
         remaining_q <= count_i - CNT_W'(1);
         down_q      <= reverse_i;
      end else if (advance_i) begin
         idx_q       <= next_idx_o;
         remaining_q <= remaining_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/frame_serializer.sv
// Snapshots a LENGTH-word signed frame on start and streams it out over valid/ready.
module frame_serializer
   import frame_pkg::*;
#(
   parameter int LENGTH    = 1024,
   parameter int WORDWIDTH = SAMPLE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        reverse,
   input  logic [$clog2(LENGTH+1)-1:0] num_words,
   input  logic signed [WORDWIDTH-1:0] frame_in [LENGTH],
   frame_serializer_if.master          out_if,
   output logic                        busy,
   output logic                        done
);

   localparam int IDX_W = idx_w(LENGTH);
   localparam int CNT_W = $clog2(LENGTH + 1);

   ser_state_t state_q, state_d;

   logic signed [WORDWIDTH-1:0] snapshot_q [LENGTH];
   logic signed [WORDWIDTH-1:0] data_q, data_d;
   logic valid_q, valid_d;
   logic last_q, last_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic             load, advance;
   logic [CNT_W-1:0] count_eff;
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] next_idx;
   logic             is_last, next_last;

   // Zero or an oversized request both mean a whole frame.
   assign count_eff = ((num_words == '0) || (num_words > CNT_W'(LENGTH))) ?
                      CNT_W'(LENGTH) : num_words;
   assign first_idx = reverse ? IDX_W'(LENGTH - 1) : '0;

   frame_index_counter #(
      .LENGTH (LENGTH),
      .IDX_W  (IDX_W),
      .CNT_W  (CNT_W)
   ) u_index (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .reverse_i   (reverse),
      .count_i     (count_eff),
      .advance_i   (advance),
      .next_idx_o  (next_idx),
      .is_last_o   (is_last),
      .next_last_o (next_last)
   );

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               load    = 1'b1;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               data_d  = frame_in[first_idx];
               last_d  = (count_eff == CNT_W'(1));
            end
         end
         STREAM: begin
            if (valid_q && out_if.out_ready) begin
               if (is_last) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  advance = 1'b1;
                  data_d  = snapshot_q[next_idx];
                  last_d  = next_last;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // NOTE: the snapshot is cleared on reset because a stale frame must never be
   // observable; arrays that are always written before use need no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         snapshot_q <= '{default: '0};
      end else if (load) begin
         snapshot_q <= frame_in;
      end
   end

   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_last  = last_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
